// File: rtl/ula_flags_stage.sv
// Writeback/flag stage behind the ALU: one-entry result buffer, N/Z/C/V flag register
// and conditional-jump resolution with same-cycle forwarding of a flag update.
module ula_flags_stage #(
    parameter int WIDTH  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic [4:0]        opcode,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              wr_en_req,
    input  logic              flags_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  wb_data,
    output logic [REG_AW-1:0] wb_addr,
    output logic              flag_neg,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_ovf,
    input  logic              jmp_req,
    input  logic [2:0]        jmp_cond,
    input  logic              jmp_inv,
    output logic              jmp_done,
    output logic              jmp_taken
);

    logic accept;
    logic flag_upd;
    logic is_arith;
    logic nxt_neg, nxt_zero, nxt_carry, nxt_ovf;
    logic eff_neg, eff_zero, eff_carry, eff_ovf;
    logic cond_met;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign flag_upd = accept && flags_en;

    // Only arithmetic opcodes propagate the ALU's carry/overflow; everything else clears them.
    always_comb begin
        is_arith = 1'b0;
        case (opcode)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: is_arith = 1'b1;
            default:                      is_arith = 1'b0;
        endcase
    end

    always_comb begin
        nxt_zero  = (alu_out == '0);
        nxt_neg   = alu_out[WIDTH-1];
        nxt_carry = is_arith && alu_carry;
        nxt_ovf   = is_arith && alu_overflow;
    end

    // A jump in the same cycle as a flag update sees the new flags.
    always_comb begin
        eff_neg   = flag_upd ? nxt_neg   : flag_neg;
        eff_zero  = flag_upd ? nxt_zero  : flag_zero;
        eff_carry = flag_upd ? nxt_carry : flag_carry;
        eff_ovf   = flag_upd ? nxt_ovf   : flag_ovf;
        cond_met  = 1'b0;
        case (jmp_cond)
            3'b000:  cond_met = 1'b1;
            3'b001:  cond_met = eff_neg;
            3'b010:  cond_met = eff_zero;
            3'b011:  cond_met = eff_carry;
            3'b100:  cond_met = eff_neg || eff_zero;
            3'b101:  cond_met = eff_ovf;
            3'b110:  cond_met = !eff_neg && !eff_zero;
            default: cond_met = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            wb_data   <= '0;
            wb_addr   <= '0;
        end else if (accept && wr_en_req) begin
            out_valid <= 1'b1;
            wb_data   <= alu_out;
            wb_addr   <= rd_addr;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_neg   <= 1'b0;
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
        end else if (flag_upd) begin
            flag_neg   <= nxt_neg;
            flag_zero  <= nxt_zero;
            flag_carry <= nxt_carry;
            flag_ovf   <= nxt_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jmp_done  <= 1'b0;
            jmp_taken <= 1'b0;
        end else begin
            jmp_done <= jmp_req;
            if (jmp_req) begin
                jmp_taken <= cond_met ^ jmp_inv;
            end
        end
    end

endmodule

// File: tb/tb_ula_flags_stage.sv
// Randomized scoreboard bench for ula_flags_stage: a cycle-level reference model queues
// expected flags/jump results and writebacks, and a monitor process compares them.
module tb_ula_flags_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_out;
    logic        alu_carry;
    logic        alu_overflow;
    logic [4:0]  opcode;
    logic [4:0]  rd_addr;
    logic        wr_en_req;
    logic        flags_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        flag_neg, flag_zero, flag_carry, flag_ovf;
    logic        jmp_req;
    logic [2:0]  jmp_cond;
    logic        jmp_inv;
    logic        jmp_done;
    logic        jmp_taken;

    ula_flags_stage #(.WIDTH(32), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .opcode(opcode), .rd_addr(rd_addr), .wr_en_req(wr_en_req), .flags_en(flags_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .wb_data(wb_data), .wb_addr(wb_addr),
        .flag_neg(flag_neg), .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_ovf(flag_ovf),
        .jmp_req(jmp_req), .jmp_cond(jmp_cond), .jmp_inv(jmp_inv),
        .jmp_done(jmp_done), .jmp_taken(jmp_taken)
    );

    typedef struct packed {
        logic outValid;
        logic neg;
        logic zero;
        logic carry;
        logic ovf;
        logic jmpDone;
        logic taken;
    } exp_t;

    exp_t        expQ[$];
    logic [36:0] wbQ[$];
    exp_t        pendExp;
    logic        haveExp;
    logic        monEn;
    int          testsRun;
    int          testsFailed;

    // Reference model state: pending write count and architectural flags.
    int          mPending;
    logic        mNeg, mZero, mCarry, mOvf, mTaken;
    logic        lastStall;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic c, input logic o,
                                 input logic [4:0] op, input logic [4:0] rd, input logic we,
                                 input logic fe, input logic ordy, input logic jr,
                                 input logic [2:0] jc, input logic ji);
        logic       ready, acc, cond;
        logic [7:0] condVec;
        @(posedge clk);
        if (haveExp) expQ.push_back(pendExp);
        #1;
        in_valid = v; alu_out = d; alu_carry = c; alu_overflow = o; opcode = op;
        rd_addr = rd; wr_en_req = we; flags_en = fe; out_ready = ordy;
        jmp_req = jr; jmp_cond = jc; jmp_inv = ji;

        ready = (mPending == 0) || ordy;
        acc   = v && ready;
        lastStall = v && !ready;
        if (acc && fe) begin
            mZero = (d == 32'd0);
            mNeg  = (d >= 32'h8000_0000);
            if (op inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6}) begin
                mCarry = c;
                mOvf   = o;
            end else begin
                mCarry = 1'b0;
                mOvf   = 1'b0;
            end
        end
        if (acc && we) begin
            wbQ.push_back({rd, d});
            mPending = 1;
        end else if (mPending > 0 && ordy) begin
            mPending = 0;
        end
        if (jr) begin
            condVec = {1'b0, !mNeg && !mZero, mOvf, mNeg || mZero, mCarry, mZero, mNeg, 1'b1};
            cond    = condVec[jc];
            mTaken  = cond ^ ji;
        end
        pendExp = '{outValid: (mPending != 0), neg: mNeg, zero: mZero, carry: mCarry,
                    ovf: mOvf, jmpDone: jr, taken: mTaken};
        haveExp = 1'b1;
    endtask

    // Monitor: compare per-cycle expectations and the writeback buffer against the queues.
    always begin
        exp_t e;
        @(posedge clk);
        #3;
        if (monEn && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("out_valid", out_valid, e.outValid);
            checkOutput("in_ready", in_ready, !e.outValid || out_ready);
            checkOutput("flag_neg", flag_neg, e.neg);
            checkOutput("flag_zero", flag_zero, e.zero);
            checkOutput("flag_carry", flag_carry, e.carry);
            checkOutput("flag_ovf", flag_ovf, e.ovf);
            checkOutput("jmp_done", jmp_done, e.jmpDone);
            checkOutput("jmp_taken", jmp_taken, e.taken);
        end
        if (monEn && out_valid) begin
            if (wbQ.size() == 0) begin
                checkOutput("wb_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("wb_data", wb_data, wbQ[0][31:0]);
                checkOutput("wb_addr", {27'd0, wb_addr}, {27'd0, wbQ[0][36:32]});
                if (out_ready) void'(wbQ.pop_front());
            end
        end
    end

    initial begin
        testsRun = 0; testsFailed = 0; monEn = 1'b0; haveExp = 1'b0; lastStall = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; alu_out = '0; alu_carry = 1'b0; alu_overflow = 1'b0;
        opcode = '0; rd_addr = '0; wr_en_req = 1'b0; flags_en = 1'b0; out_ready = 1'b0;
        jmp_req = 1'b0; jmp_cond = '0; jmp_inv = 1'b0;
        #12;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_jmp_done", jmp_done, 0);
        checkOutput("rst_jmp_taken", jmp_taken, 0);
        rst_n = 1'b1;

        // Reset while a write is stalled in the buffer.
        @(posedge clk); #1;
        in_valid = 1'b1; alu_out = 32'h1234; rd_addr = 5'd3; wr_en_req = 1'b1;
        flags_en = 1'b1; opcode = 5'b00000; alu_carry = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        checkOutput("stall_out_valid", out_valid, 1);
        checkOutput("stall_wb_data", wb_data, 32'h1234);
        checkOutput("stall_wb_addr", {27'd0, wb_addr}, 3);
        checkOutput("stall_flag_carry", flag_carry, 1);
        checkOutput("stall_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_wb_addr", {27'd0, wb_addr}, 0);
        checkOutput("midrst_flags", {28'd0, flag_neg, flag_zero, flag_carry, flag_ovf}, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;

        mPending = 0; mNeg = 0; mZero = 0; mCarry = 0; mOvf = 0; mTaken = 0;
        monEn = 1'b1;

        // Add wrap, jump on carry next cycle, then a logic op clearing C/V.
        applyStimulus(1, 32'h0, 1, 0, 5'b00000, 5'd1, 1, 1, 1, 0, 3'b000, 0);
        applyStimulus(0, 32'h0, 0, 0, 5'b00000, 5'd0, 0, 0, 1, 1, 3'b011, 0);
        applyStimulus(1, 32'h8000_0000, 1, 1, 5'b10001, 5'd2, 1, 1, 1, 0, 3'b000, 0);
        // Backpressure: three results with out_ready low for two cycles.
        applyStimulus(1, 32'hA1, 0, 0, 5'b00001, 5'd4, 1, 0, 0, 0, 3'b000, 0);
        applyStimulus(1, 32'hB2, 0, 0, 5'b00001, 5'd5, 1, 0, 0, 0, 3'b000, 0);
        applyStimulus(1, 32'hB2, 0, 0, 5'b00001, 5'd5, 1, 0, 1, 0, 3'b000, 0);
        applyStimulus(1, 32'hC3, 0, 0, 5'b00001, 5'd6, 1, 0, 1, 0, 3'b000, 0);
        // Forwarding: zero result and inverted jump-on-zero in the same cycle.
        applyStimulus(1, 32'h5, 0, 0, 5'b00011, 5'd7, 1, 1, 1, 0, 3'b000, 0);
        applyStimulus(1, 32'h0, 0, 0, 5'b00011, 5'd8, 1, 1, 1, 1, 3'b010, 1);
        // Flag-only entries, with and without a flag update.
        applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 5'b10000, 5'd9, 0, 1, 1, 0, 3'b000, 0);
        applyStimulus(1, 32'h0, 1, 1, 5'b00000, 5'd9, 0, 0, 1, 1, 3'b001, 0);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] d;
            if (lastStall) begin
                applyStimulus(in_valid, alu_out, alu_carry, alu_overflow, opcode, rd_addr,
                              wr_en_req, flags_en, ($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                              1'($urandom_range(0, 1)));
            end else begin
                case ($urandom_range(0, 3))
                    0:       d = 32'd0;
                    1:       d = 32'h8000_0000 | $urandom;
                    default: d = $urandom;
                endcase
                applyStimulus(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                              5'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                              1'($urandom_range(0, 1)));
            end
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0, 0, 0, 5'd0, 5'd0, 0, 0, 1, 0, 3'b000, 0);
        end
        @(posedge clk);
        expQ.push_back(pendExp);
        #5;
        monEn = 1'b0;
        checkOutput("wb_queue_empty", wbQ.size(), 0);
        checkOutput("exp_queue_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ula_flags_stage.md
# ula_flags_stage

Writeback/flag stage directly downstream of the ALU. Accepts one ALU result per handshake, derives and holds the processor condition flags (negative, zero, carry, overflow), and buffers the result in a one-entry register for the register-file write port. It also resolves conditional-jump requests against the flag register, with same-cycle forwarding of a flag update.

## Interface
- WIDTH, 32, datapath width of ALU result and writeback data
- REG_AW, 5, register-file address width
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  ALU result and controls valid this cycle
- in_ready  output  1  stage can accept; equals !out_valid || out_ready
- alu_out  input  WIDTH  ALU result
- alu_carry  input  1  ALU carry indication
- alu_overflow  input  1  ALU overflow indication
- opcode  input  5  ALU opcode of this result
- rd_addr  input  REG_AW  destination register
- wr_en_req  input  1  result is written to register file
- flags_en  input  1  result updates the flag register
- out_valid  output  1  wb_data/wb_addr hold a pending write
- out_ready  input  1  register file takes the write this cycle
- wb_data  output  WIDTH  buffered result
- wb_addr  output  REG_AW  buffered destination
- flag_neg, flag_zero, flag_carry, flag_ovf  output  1 each  flag register
- jmp_req  input  1  evaluate a jump condition this cycle
- jmp_cond  input  3  condition select
- jmp_inv  input  1  invert condition (jump-if-false)
- jmp_done  output  1  one-cycle pulse, jmp_taken valid
- jmp_taken  output  1  jump decision

## Operation
- Accept = in_valid && in_ready. Nothing is captured when accept is 0.
- On accept with wr_en_req=1: wb_data<=alu_out, wb_addr<=rd_addr, out_valid<=1.
- On accept with wr_en_req=0: output buffer unchanged apart from the rule below; entry is flag-only.
- out_valid clears when out_valid && out_ready && !(accept && wr_en_req). Drain and refill in the same cycle keeps out_valid=1 with the new data.
- Flag update on accept with flags_en=1:
  - flag_zero = (alu_out == 0), computed here, not taken from ALU.
  - flag_neg = alu_out[WIDTH-1].
  - Arithmetic opcodes 00000, 00001, 00011, 00100, 00101, 00110: flag_carry=alu_carry, flag_ovf=alu_overflow.
  - All other opcodes: flag_carry=0, flag_ovf=0.
- flags_en=0: flags hold.
- Jump conditions: 000 always, 001 neg, 010 zero, 011 carry, 100 neg|zero, 101 ovf, 110 !neg&!zero (positive), 111 never. jmp_taken = cond XOR jmp_inv.
- Forwarding: when jmp_req coincides with a flag-updating accept, the condition uses the new flag values.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, wb_data=0, wb_addr=0, all flags=0, jmp_done=0, jmp_taken=0. in_ready=1 once out_valid=0. A buffered, undrained entry is discarded.
- Result latency: accept at edge N -> out_valid=1 and data visible after edge N. Stays until out_ready sampled high.
- Throughput: one result per cycle while out_ready=1.
- Backpressure: out_valid=1 and out_ready=0 -> in_ready=0; wb_data/wb_addr stable.
- Flags are registered and visible the cycle after accept.
- jmp_req at edge N -> jmp_done=1 and jmp_taken for exactly the cycle after N. Back-to-back jmp_req gives back-to-back pulses. jmp_taken holds its last value while jmp_done=0.
- in_valid with in_ready=0: inputs ignored and no flag change; upstream must hold.

## Test plan
- Reset mid-stall: accept 0x1234 to r3, out_ready=0, assert rst_n=0 -> out_valid=0, flags 0 immediately; after release in_ready=1.
- Add wrap: opcode 00000, alu_out=0, carry=1, ovf=0, flags_en=1 -> flag_zero=1, flag_carry=1, flag_neg=0; jmp_cond=011 the following cycle -> jmp_taken=1.
- Logic clears C/V: after the previous step, opcode 10001, alu_out=0x80000000 -> flag_neg=1, flag_zero=0, flag_carry=0, flag_ovf=0.
- Backpressure: three back-to-back results, out_ready low for 2 cycles -> in_ready=0 while full, wb_data holds the first value, then all three are delivered in order without loss or duplication.
- Forwarding: accept alu_out=0 with flags_en=1 and jmp_req with jmp_cond=010, jmp_inv=1 in the same cycle, old flag_zero=0 -> jmp_taken=0 and jmp_done=1 the next cycle.
- Flag-only entry: wr_en_req=0, flags_en=1, alu_out=0xFFFFFFFF -> out_valid unchanged, flag_neg=1; with flags_en=0 instead, flags unchanged.
